// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU pipeline control slice.
// Register-file geometry and the pipeline sequencer state encoding.
package cpu_pkg;

  localparam int unsigned NREG = 16;
  localparam int unsigned REGW = $clog2(NREG);

  typedef enum logic [0:0] {
    RUN,
    JB_WAIT
  } pipe_state_t;

endpackage

// File: rtl/cpu_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Two source read ports plus a destination (WAW) read port.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned NREG = cpu_pkg::NREG,
  parameter int unsigned REGW = cpu_pkg::REGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [REGW-1:0] set_idx,
  input  logic            clr_en,
  input  logic [REGW-1:0] clr_idx,
  input  logic [REGW-1:0] rd1_idx,
  input  logic [REGW-1:0] rd2_idx,
  input  logic [REGW-1:0] waw_idx,
  output logic            rd1_busy,
  output logic            rd2_busy,
  output logic            waw_busy,
  output logic [NREG-1:0] sb
);

  logic [NREG-1:0] sb_q, sb_d;

  // Clear first so a same-index set in the same cycle wins.
  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_idx] = 1'b0;
    if (set_en) sb_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign rd1_busy = sb_q[rd1_idx];
  assign rd2_busy = sb_q[rd2_idx];
  assign waw_busy = sb_q[waw_idx];
  assign sb       = sb_q;

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Central sequencer for the 5-stage pipeline: hazard-gated issue, jump/branch
// fetch freeze and redirect, global memory-wait freeze, and a stall counter.
module cpu_pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned NREG = cpu_pkg::NREG,
  parameter int unsigned REGW = cpu_pkg::REGW,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dec_valid,
  input  logic [REGW-1:0] dec_rs1,
  input  logic [REGW-1:0] dec_rs2,
  input  logic            dec_rs1_used,
  input  logic            dec_rs2_used,
  input  logic            dec_wrt_en,
  input  logic [REGW-1:0] dec_wrt_reg,
  input  logic            dec_is_jb,
  input  logic            exec_jb_resolve,
  input  logic            exec_jb_taken,
  input  logic            mem_busy,
  input  logic            wb_wrt_en,
  input  logic [REGW-1:0] wb_wrt_reg,
  output logic            pc_en,
  output logic            pc_sel_target,
  output logic            if_dec_en,
  output logic            dec_flush,
  output logic            issue,
  output logic            exec_bubble,
  output logic            pipe_en,
  output logic [NREG-1:0] scoreboard,
  output logic [CNTW-1:0] stall_cycles
);

  pipe_state_t     state_q, state_d;
  logic [CNTW-1:0] stall_q, stall_d;
  logic            rs1_busy, rs2_busy, waw_busy, hazard;
  logic            pc_en_c, pc_sel_c, if_dec_en_c, dec_flush_c;
  logic            issue_c, exec_bubble_c, pipe_en_c;

  cpu_scoreboard #(
    .NREG (NREG),
    .REGW (REGW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue & dec_wrt_en),
    .set_idx  (dec_wrt_reg),
    .clr_en   (wb_wrt_en & pipe_en),
    .clr_idx  (wb_wrt_reg),
    .rd1_idx  (dec_rs1),
    .rd2_idx  (dec_rs2),
    .waw_idx  (dec_wrt_reg),
    .rd1_busy (rs1_busy),
    .rd2_busy (rs2_busy),
    .waw_busy (waw_busy),
    .sb       (scoreboard)
  );

  assign hazard = (dec_rs1_used & rs1_busy) | (dec_rs2_used & rs2_busy) |
                  (dec_wrt_en & waw_busy);

  always_comb begin
    state_d       = state_q;
    pc_en_c       = 1'b0;
    pc_sel_c      = 1'b0;
    if_dec_en_c   = 1'b0;
    dec_flush_c   = 1'b0;
    issue_c       = 1'b0;
    exec_bubble_c = 1'b0;
    pipe_en_c     = 1'b0;
    // A memory wait freezes everything; EXEC keeps presenting its resolve.
    if (!mem_busy) begin
      pipe_en_c = 1'b1;
      unique case (state_q)
        RUN: begin
          issue_c       = dec_valid & ~hazard;
          exec_bubble_c = ~issue_c;
          pc_en_c       = issue_c | ~dec_valid;
          if_dec_en_c   = issue_c | ~dec_valid;
          if (issue_c && dec_is_jb) state_d = JB_WAIT;
        end
        JB_WAIT: begin
          exec_bubble_c = 1'b1;
          if (exec_jb_resolve) begin
            pc_en_c = 1'b1;
            state_d = RUN;
            // Not taken: the held fall-through instruction in DEC is already correct.
            if (exec_jb_taken) begin
              pc_sel_c    = 1'b1;
              dec_flush_c = 1'b1;
              if_dec_en_c = 1'b1;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (dec_valid && !issue && !(&stall_q)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign pc_en         = rst_n & pc_en_c;
  assign pc_sel_target = rst_n & pc_sel_c;
  assign if_dec_en     = rst_n & if_dec_en_c;
  assign dec_flush     = rst_n & dec_flush_c;
  assign issue         = rst_n & issue_c;
  assign exec_bubble   = rst_n & exec_bubble_c;
  assign pipe_en       = rst_n & pipe_en_c;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Self-checking bench for cpu_pipe_ctrl: expected enable vectors are queued as
// stimulus is driven and compared when the cycle's outputs settle.
module tb_cpu_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, rst_n2;
  logic       dec_valid, dec_rs1_used, dec_rs2_used, dec_wrt_en, dec_is_jb;
  logic [3:0] dec_rs1, dec_rs2, dec_wrt_reg, wb_wrt_reg;
  logic       exec_jb_resolve, exec_jb_taken, mem_busy, wb_wrt_en;

  logic        pc_en, pc_sel_target, if_dec_en, dec_flush, issue, exec_bubble, pipe_en;
  logic [15:0] scoreboard, stall_cycles;

  logic        pc_en2, pc_sel2, if_dec_en2, dec_flush2, issue2, exec_bubble2, pipe_en2;
  logic [15:0] scoreboard2;
  logic [3:0]  stall_cycles2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall  = 0;
  int exp_stall2 = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  cpu_pipe_ctrl u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dec_valid       (dec_valid),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .dec_rs1_used    (dec_rs1_used),
    .dec_rs2_used    (dec_rs2_used),
    .dec_wrt_en      (dec_wrt_en),
    .dec_wrt_reg     (dec_wrt_reg),
    .dec_is_jb       (dec_is_jb),
    .exec_jb_resolve (exec_jb_resolve),
    .exec_jb_taken   (exec_jb_taken),
    .mem_busy        (mem_busy),
    .wb_wrt_en       (wb_wrt_en),
    .wb_wrt_reg      (wb_wrt_reg),
    .pc_en           (pc_en),
    .pc_sel_target   (pc_sel_target),
    .if_dec_en       (if_dec_en),
    .dec_flush       (dec_flush),
    .issue           (issue),
    .exec_bubble     (exec_bubble),
    .pipe_en         (pipe_en),
    .scoreboard      (scoreboard),
    .stall_cycles    (stall_cycles)
  );

  cpu_pipe_ctrl #(
    .CNTW (4)
  ) u_dut_sat (
    .clk             (clk),
    .rst_n           (rst_n2),
    .dec_valid       (dec_valid),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .dec_rs1_used    (dec_rs1_used),
    .dec_rs2_used    (dec_rs2_used),
    .dec_wrt_en      (dec_wrt_en),
    .dec_wrt_reg     (dec_wrt_reg),
    .dec_is_jb       (dec_is_jb),
    .exec_jb_resolve (exec_jb_resolve),
    .exec_jb_taken   (exec_jb_taken),
    .mem_busy        (mem_busy),
    .wb_wrt_en       (wb_wrt_en),
    .wb_wrt_reg      (wb_wrt_reg),
    .pc_en           (pc_en2),
    .pc_sel_target   (pc_sel2),
    .if_dec_en       (if_dec_en2),
    .dec_flush       (dec_flush2),
    .issue           (issue2),
    .exec_bubble     (exec_bubble2),
    .pipe_en         (pipe_en2),
    .scoreboard      (scoreboard2),
    .stall_cycles    (stall_cycles2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    dec_wrt_en = 0; dec_wrt_reg = 0; dec_is_jb = 0; exec_jb_resolve = 0;
    exec_jb_taken = 0; mem_busy = 0; wb_wrt_en = 0; wb_wrt_reg = 0;
  endtask

  // exp = {pc_en, pc_sel_target, if_dec_en, dec_flush, issue, exec_bubble, pipe_en}
  task automatic step(input string tag, input logic [6:0] exp);
    logic [6:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #2;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {25'd0, pc_en, pc_sel_target, if_dec_en, dec_flush, issue, exec_bubble, pipe_en},
        {25'd0, e});
    chk({t, "_stall"}, {16'd0, stall_cycles}, exp_stall);
    chk({t, "_stall4"}, {28'd0, stall_cycles2}, exp_stall2);
    if (rst_n && dec_valid && !e[2]) exp_stall++;
    if (rst_n2 && dec_valid && !e[2] && exp_stall2 != 15) exp_stall2++;
    if (!rst_n)  exp_stall  = 0;
    if (!rst_n2) exp_stall2 = 0;
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] VIss  = 7'b1010101;
  localparam logic [6:0] VStl  = 7'b0000011;
  localparam logic [6:0] VIdle = 7'b1010011;
  localparam logic [6:0] VTkn  = 7'b1111011;
  localparam logic [6:0] VNtk  = 7'b1000011;
  localparam logic [6:0] VFrz  = 7'b0000000;

  initial begin
    clr_in();
    rst_n = 0; rst_n2 = 0;
    repeat (2) @(posedge clk);
    #1;
    // Outputs held low in reset even with a valid instruction present.
    dec_valid = 1;
    step("rst", VFrz);
    chk("rst_sb", {16'd0, scoreboard}, 0);
    rst_n = 1;

    // RAW on r3: stall until WB clears, issue the cycle after.
    clr_in(); dec_valid = 1; dec_rs1 = 1; dec_rs1_used = 1; dec_wrt_en = 1; dec_wrt_reg = 3;
    step("add_r3", VIss);
    chk("sb_r3_set", {16'd0, scoreboard}, 32'h8);
    clr_in(); dec_valid = 1; dec_rs1 = 3; dec_rs1_used = 1;
    step("raw1", VStl);
    step("raw2", VStl);
    wb_wrt_en = 1; wb_wrt_reg = 3;
    step("raw_wb", VStl);
    chk("sb_r3_clr", {16'd0, scoreboard}, 0);
    wb_wrt_en = 0;
    step("raw_go", VIss);

    // rs2 gating and WAW.
    clr_in(); dec_valid = 1; dec_wrt_en = 1; dec_wrt_reg = 7;
    step("add_r7", VIss);
    clr_in(); dec_valid = 1; dec_rs2 = 7; dec_rs1_used = 1;
    step("rs2_unused", VIss);
    dec_rs2_used = 1;
    step("rs2_haz", VStl);
    clr_in(); dec_valid = 1; dec_wrt_en = 1; dec_wrt_reg = 7;
    step("waw", VStl);
    clr_in(); wb_wrt_en = 1; wb_wrt_reg = 7;
    step("wb_r7", VIdle);
    chk("sb_r7_clr", {16'd0, scoreboard}, 0);

    // Taken branch resolved after three wait cycles.
    clr_in(); dec_valid = 1; dec_is_jb = 1;
    step("jb_t_issue", VIss);
    clr_in(); dec_valid = 1;
    repeat (3) step("jb_wait", VStl);
    exec_jb_resolve = 1; exec_jb_taken = 1;
    step("jb_taken", VTkn);
    clr_in();
    step("jb_t_after", VIdle);

    // Not-taken branch.
    clr_in(); dec_valid = 1; dec_is_jb = 1;
    step("jb_nt_issue", VIss);
    clr_in(); dec_valid = 1; exec_jb_resolve = 1;
    step("jb_nt", VNtk);
    clr_in(); dec_valid = 1;
    step("jb_nt_next", VIss);
    clr_in(); exec_jb_resolve = 1; exec_jb_taken = 1;
    step("resolve_in_run", VIdle);

    // Memory freeze during JB_WAIT with resolve held.
    clr_in(); dec_valid = 1; dec_is_jb = 1;
    step("jb_f_issue", VIss);
    clr_in(); dec_valid = 1; mem_busy = 1; exec_jb_resolve = 1; exec_jb_taken = 1;
    repeat (4) step("frz", VFrz);
    mem_busy = 0;
    step("frz_resolve", VTkn);
    clr_in();
    step("frz_after", VIdle);

    // Same-cycle set and clear of r5: set wins; clears ignored while frozen.
    clr_in(); dec_valid = 1; dec_wrt_en = 1; dec_wrt_reg = 5; wb_wrt_en = 1; wb_wrt_reg = 5;
    step("set_clr_r5", VIss);
    chk("sb_r5_set_wins", {16'd0, scoreboard}, 32'h20);
    clr_in(); mem_busy = 1; wb_wrt_en = 1; wb_wrt_reg = 5;
    step("frz_wb", VFrz);
    chk("sb_r5_frz_hold", {16'd0, scoreboard}, 32'h20);

    // Reset in the middle of JB_WAIT.
    clr_in(); dec_valid = 1; dec_is_jb = 1;
    step("jb_r_issue", VIss);
    clr_in(); dec_valid = 1; rst_n = 0;
    step("rst_jbw", VFrz);
    chk("rst_jbw_sb", {16'd0, scoreboard}, 0);
    rst_n = 1;
    step("rst_run", VIss);

    // Saturation of a 4-bit counter on a 21-cycle hazard.
    clr_in(); rst_n2 = 1; dec_valid = 1; dec_wrt_en = 1; dec_wrt_reg = 9;
    step("add_r9", VIss);
    clr_in(); dec_valid = 1; dec_rs1 = 9; dec_rs1_used = 1;
    repeat (20) step("sat_haz", VStl);
    chk("sat15", {28'd0, stall_cycles2}, 15);
    wb_wrt_en = 1; wb_wrt_reg = 9;
    step("sat_wb", VStl);
    wb_wrt_en = 0;
    step("sat_go", VIss);
    chk("sat_hold", {28'd0, stall_cycles2}, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
